vga_frame_reader: RTL

- Scan-out stage directly downstream of the image processing stage.
- Reads 8-bit grayscale pixels from the output framebuffer RAM that the processing stage writes.
- Generates 640x480@60 VGA timing and shows the image centred in the active area; everything outside the image window is black.
- Display of a frame is gated by the processing stage's completion flag, latched once per frame so a partially written image never tears mid-frame.

---
 rtl/vga_frame_reader_if.sv | 21 ++
 rtl/vga_frame_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port between the scan-out reader and the output RAM.
// The reader drives address/enable; the RAM returns one byte per read.
interface vga_frame_reader_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] RD_ADDR;
    logic              RD_EN;
    logic [7:0]        RD_DATA;

    modport master (
        output RD_ADDR,
        output RD_EN,
        input  RD_DATA
    );

    modport slave (
        input  RD_ADDR,
        input  RD_EN,
        output RD_DATA
    );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA scan-out of a centred grayscale image from the output framebuffer.
// A frame is shown only if IMG_READY was high at its first pixel.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PIX_EN,
    input  logic               IMG_READY,
    vga_frame_reader_if.master fb,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               FRAME_START,
    output logic               SHOWING
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int X0      = (H_ACTIVE - IMG_W) / 2;
    localparam int Y0      = (V_ACTIVE - IMG_H) / 2;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_WLO   = HW'(X0);
    localparam logic [HW-1:0] H_WHI   = HW'(X0 + IMG_W - 1);
    localparam logic [HW-1:0] H_SLO   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SHI   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_WLO   = VW'(Y0);
    localparam logic [VW-1:0] V_WHI   = VW'(Y0 + IMG_H - 1);
    localparam logic [VW-1:0] V_SLO   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SHI   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0]     r_h;
    logic [VW-1:0]     r_v;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic              r_showing;

    logic              r_d1_hs;
    logic              r_d1_vs;
    logic              r_d1_act;
    logic              r_d1_win;
    logic              r_d1_fs;

    logic              r_hs;
    logic              r_vs;
    logic              r_blank_n;
    logic [7:0]        r_pix;
    logic              r_fs;

    logic              w_h_last;
    logic              w_v_last;
    logic              w_frame0;
    logic              w_active;
    logic              w_in_win;
    logic              w_hs_n;
    logic              w_vs_n;
    logic              w_show;
    logic              w_fetch;
    logic [ADDR_W-1:0] w_addr_cur;

    // Stage 0: decode the current raster position
    always_comb begin
        w_h_last   = (r_h == H_LAST);
        w_v_last   = (r_v == V_LAST);
        w_frame0   = (r_h == '0) && (r_v == '0);
        w_active   = (r_h < H_ACT) && (r_v < V_ACT);
        w_in_win   = w_active
                   && (r_h >= H_WLO) && (r_h <= H_WHI)
                   && (r_v >= V_WLO) && (r_v <= V_WHI);
        w_hs_n     = !((r_h >= H_SLO) && (r_h <= H_SHI));
        w_vs_n     = !((r_v >= V_SLO) && (r_v <= V_SHI));
        // The frame's first pixel already obeys the freshly latched flag
        w_show     = w_frame0 ? IMG_READY : r_showing;
        w_fetch    = w_in_win && w_show;
        w_addr_cur = w_frame0 ? '0 : r_addr;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_h <= '0;
            r_v <= '0;
        end else if (PIX_EN) begin
            r_h <= w_h_last ? '0 : r_h + HW'(1);
            if (w_h_last) begin
                r_v <= w_v_last ? '0 : r_v + VW'(1);
            end
        end
    end

    // Stage 1: framebuffer request and delayed timing flags
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_showing <= 1'b0;
            r_addr    <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_d1_hs   <= 1'b1;
            r_d1_vs   <= 1'b1;
            r_d1_act  <= 1'b0;
            r_d1_win  <= 1'b0;
            r_d1_fs   <= 1'b0;
        end else if (PIX_EN) begin
            r_showing <= w_show;
            r_rd_addr <= w_addr_cur;
            r_rd_en   <= w_fetch;
            r_addr    <= w_fetch ? w_addr_cur + ADDR_W'(1)
                                 : w_addr_cur;
            r_d1_hs   <= w_hs_n;
            r_d1_vs   <= w_vs_n;
            r_d1_act  <= w_active;
            r_d1_win  <= w_fetch;
            r_d1_fs   <= w_frame0;
        end
    end

    // Stage 2: RAM data arrives here, aligned with its sync flags
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_pix     <= 8'h00;
            r_fs      <= 1'b0;
        end else if (PIX_EN) begin
            r_hs      <= r_d1_hs;
            r_vs      <= r_d1_vs;
            r_blank_n <= r_d1_act;
            r_pix     <= r_d1_win ? fb.RD_DATA : 8'h00;
            r_fs      <= r_d1_fs;
        end
    end

    assign fb.RD_ADDR  = r_rd_addr;
    assign fb.RD_EN    = r_rd_en;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_R       = r_pix;
    assign VGA_G       = r_pix;
    assign VGA_B       = r_pix;
    assign FRAME_START = r_fs;
    assign SHOWING     = r_showing;
endmodule
